// File: rtl/conv_frame_ctrl.sv
// Frame-level sequencer for the 3x3 Sobel convolution engine.
// Accepts a raw pixel stream, forwards it to the engine with x/y coordinates,
// latches the filter direction per frame, counts filtered output pixels, and
// reports frame completion or abort (early SOF, drain timeout).
module conv_frame_ctrl #(
  parameter int WIDTH         = 1280,
  parameter int HEIGHT        = 960,
  parameter int DATA_W        = 12,
  parameter int DRAIN_TIMEOUT = 8192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode_req,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [DATA_W-1:0] pix_data,
  output logic              conv_read,
  output logic [10:0]       conv_x,
  output logic [10:0]       conv_y,
  output logic [DATA_W-1:0] conv_data_in,
  output logic              conv_vertical,
  input  logic              conv_valid,
  input  logic [DATA_W-1:0] conv_data_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              frame_done,
  output logic [1:0]        err
);

  localparam int CNT_W  = 21;
  localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TOTAL  = CNT_W'(WIDTH * HEIGHT);
  localparam logic [10:0]       LAST_X = 11'(WIDTH - 1);
  localparam logic [10:0]       LAST_Y = 11'(HEIGHT - 1);
  localparam logic [IDLE_W-1:0] TO_M1  = IDLE_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  // x_q/y_q hold the position the next accepted STREAM pixel will take
  logic [10:0]        x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               read_q, read_d;
  logic [10:0]        cx_q, cx_d, cy_q, cy_d;
  logic [DATA_W-1:0]  cdata_q, cdata_d;
  logic               vert_q, vert_d;
  logic               oval_q, oval_d;
  logic [DATA_W-1:0]  odata_q, odata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [1:0]         err_q, err_d;

  logic [10:0]        px, py;
  logic               is_last, accept, reached;

  // Next-state and registered-output computation for the frame sequencer
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    read_d  = 1'b0;
    cx_d    = cx_q;
    cy_d    = cy_q;
    cdata_d = cdata_q;
    vert_d  = vert_q;
    oval_d  = 1'b0;
    odata_d = odata_q;
    err_d   = err_q;

    // The SOF pixel accepted in ARM is always (0,0), whatever x_q/y_q hold
    px      = (state_q == S_ARM) ? 11'd0 : x_q;
    py      = (state_q == S_ARM) ? 11'd0 : y_q;
    is_last = (px == LAST_X) && (py == LAST_Y);
    accept  = pix_valid && (((state_q == S_ARM) && pix_sof) ||
                            ((state_q == S_STREAM) && !pix_sof));

    // Engine outputs are forwarded and counted only while a frame is live
    if (((state_q == S_STREAM) || (state_q == S_DRAIN)) && conv_valid) begin
      oval_d  = 1'b1;
      odata_d = conv_data_out;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
    if ((state_q == S_ARM) && accept) cnt_d = '0;
    reached = (cnt_d >= TOTAL);

    if (accept) begin
      read_d  = 1'b1;
      cx_d    = px;
      cy_d    = py;
      cdata_d = pix_data;
      idle_d  = '0;
      if (px == LAST_X) begin
        x_d = 11'd0;
        y_d = py + 11'd1;
      end else begin
        x_d = px + 11'd1;
        y_d = py;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d   = 2'b00;
          vert_d  = mode_req;
          state_d = S_ARM;
        end
      end
      S_ARM, S_STREAM: begin
        if ((state_q == S_STREAM) && pix_valid && pix_sof) begin
          err_d[0] = 1'b1;
          state_d  = S_IDLE;
        end else if (accept) begin
          if (!is_last)     state_d = S_STREAM;
          else if (reached) state_d = S_DONE;
          else              state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Completion is checked first so it wins over a coincident timeout
        if (reached) begin
          state_d = S_DONE;
        end else if (conv_valid) begin
          idle_d = '0;
        end else if (idle_q == TO_M1) begin
          err_d[1] = 1'b1;
          state_d  = S_IDLE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      read_q  <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      cdata_q <= '0;
      vert_q  <= 1'b0;
      oval_q  <= 1'b0;
      odata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      read_q  <= read_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      cdata_q <= cdata_d;
      vert_q  <= vert_d;
      oval_q  <= oval_d;
      odata_q <= odata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign conv_read     = read_q;
  assign conv_x        = cx_q;
  assign conv_y        = cy_q;
  assign conv_data_in  = cdata_q;
  assign conv_vertical = vert_q;
  assign out_valid     = oval_q;
  assign out_data      = odata_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign err           = err_q;

endmodule
